// File: rtl/mips_asm_pkg.sv
// +----------------------------------------------------------------------+
// | mips_asm_pkg                                                         |
// | Shared formats, opcodes and FSM encoding for the instruction loader. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_asm_pkg;

  localparam logic [1:0] FMT_R    = 2'd0;
  localparam logic [1:0] FMT_I    = 2'd1;
  localparam logic [1:0] FMT_J    = 2'd2;
  localparam logic [1:0] FMT_RSVD = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  function automatic logic fmt_opcode_ok(input logic [1:0] fmt, input logic [5:0] opcode);
    case (fmt)
      FMT_R:   return opcode == OP_RTYPE;
      FMT_J:   return (opcode == OP_J) || (opcode == OP_JAL);
      FMT_I:   return (opcode != OP_RTYPE) && (opcode != OP_J) && (opcode != OP_JAL);
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_word_pack.sv
// +----------------------------------------------------------------------+
// | instruction_word_pack                                                |
// | Combinational R/I/J field-to-word packer (inverse of decode).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_word_pack
  import mips_asm_pkg::*;
(
  input  logic [1:0]  i_fmt,
  input  logic [5:0]  i_opcode,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_address,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_fmt)
      FMT_R:   o_word = {i_opcode, i_rs, i_rt, i_rd, i_shamt, i_funct};
      FMT_I:   o_word = {i_opcode, i_rs, i_rt, i_imm};
      FMT_J:   o_word = {i_opcode, i_address};
      default: o_word = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instruction_assembler.sv
// +----------------------------------------------------------------------+
// | instruction_assembler                                                |
// | Packs field tuples into words and writes them to consecutive imem    |
// | addresses. Optional ASM_OPCODE_CHECK_EN rejects fmt/opcode mismatch. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module instruction_assembler
  import mips_asm_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       address,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0] c_depth    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] c_last_cnt = c_depth - (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_bad;
  logic              w_write;
  logic              w_fill;

  instruction_word_pack u_pack (
    .i_fmt     (fmt),
    .i_opcode  (opcode),
    .i_rs      (rs),
    .i_rt      (rt),
    .i_rd      (rd),
    .i_shamt   (shamt),
    .i_funct   (funct),
    .i_imm     (imm),
    .i_address (address),
    .o_word    (w_word)
  );

`ifdef ASM_OPCODE_CHECK_EN
  assign w_bad = (fmt == FMT_RSVD) || !fmt_opcode_ok(fmt, opcode);
`else
  assign w_bad = (fmt == FMT_RSVD);
`endif

  assign w_accept = in_valid & in_ready;
  assign w_write  = w_accept & ~w_bad;
  // This write fills the last free slot of imem.
  assign w_fill   = w_write & (r_count == c_last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = c_st_load;
    end else begin
      case (r_state)
        c_st_load: if (w_accept && (in_last || w_fill)) w_next = c_st_done;
        default:   w_next = r_state;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == c_st_load) && (r_count < c_depth) && !start;
    busy     = (r_state == c_st_load);
    done     = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_bad) begin
          r_err <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_word;
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W+1)'(1);
        end
        if (w_fill && !in_last) r_err <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instruction_assembler.sv
// +----------------------------------------------------------------------+
// | tb_instruction_assembler                                             |
// | Randomized and directed bench with a tuple-level loader model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_instruction_assembler;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] adr;
  } tup_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [1:0]  fmt = '0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] address = '0;

  logic        w_rdy8, w_we8, w_busy8, w_done8, w_err8;
  logic [7:0]  w_addr8;
  logic [31:0] w_wd8;
  logic [8:0]  w_cnt8;
  logic        w_rdy2, w_we2, w_busy2, w_done2, w_err2;
  logic [1:0]  w_addr2;
  logic [31:0] w_wd2;
  logic [2:0]  w_cnt2;

  int n_checks = 0, n_fail = 0;
  logic [39:0] q8[$];
  logic [33:0] q2[$];
  tup_t prog[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_cnt;
  bit          exp_err;

  always #5 clk = ~clk;

  instruction_assembler #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_rdy8),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .address(address), .imem_we(w_we8),
    .imem_addr(w_addr8), .imem_wdata(w_wd8), .busy(w_busy8), .done(w_done8),
    .count(w_cnt8), .err(w_err8)
  );

  instruction_assembler #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_rdy2),
    .in_last(in_last), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .address(address), .imem_we(w_we2),
    .imem_addr(w_addr2), .imem_wdata(w_wd2), .busy(w_busy2), .done(w_done2),
    .count(w_cnt2), .err(w_err2)
  );

  always @(negedge clk) begin
    if (w_we8) q8.push_back({w_addr8, w_wd8});
    if (w_we2) q2.push_back({w_addr2, w_wd2});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic tup_t mk(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d, input logic [4:0] h,
                              input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ad);
    tup_t x;
    x.fmt = f; x.op = op; x.rs = s; x.rt = t; x.rd = d; x.sh = h;
    x.fn = fn; x.imm = im; x.adr = ad;
    return x;
  endfunction

  function automatic tup_t rand_tup(input bit allow_bad);
    tup_t x;
    x.fmt = 2'($urandom_range(0, 2));
    if (allow_bad && $urandom_range(0, 5) == 0) x.fmt = 2'd3;
    case (x.fmt)
      2'd0:    x.op = 6'd0;
      2'd2:    x.op = 6'($urandom_range(2, 3));
      default: x.op = 6'($urandom_range(4, 63));
    endcase
    x.rs = 5'($urandom); x.rt = 5'($urandom); x.rd = 5'($urandom); x.sh = 5'($urandom);
    x.fn = 6'($urandom); x.imm = 16'($urandom); x.adr = 26'($urandom);
    return x;
  endfunction

  function automatic logic [31:0] model_word(input tup_t t);
    case (t.fmt)
      2'd0: return (32'(t.op) << 26) | (32'(t.rs) << 21) | (32'(t.rt) << 16) |
                   (32'(t.rd) << 11) | (32'(t.sh) << 6) | 32'(t.fn);
      2'd1: return (32'(t.op) << 26) | (32'(t.rs) << 21) | (32'(t.rt) << 16) | 32'(t.imm);
      2'd2: return (32'(t.op) << 26) | 32'(t.adr);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_bad(input tup_t t);
    bit b;
    b = (t.fmt == 2'd3);
`ifdef ASM_OPCODE_CHECK_EN
    if (t.fmt == 2'd0 && t.op != 6'd0) b = 1'b1;
    if (t.fmt == 2'd2 && t.op != 6'd2 && t.op != 6'd3) b = 1'b1;
    if (t.fmt == 2'd1 && t.op <= 6'd3 && t.op != 6'd1) b = 1'b1;
`endif
    return b;
  endfunction

  // Expected writes for prog[], last flag on the final element when with_last.
  task automatic model_run(input int depth, input bit with_last);
    int ptr;
    bit last;
    ptr = 0; exp_cnt = 0; exp_err = 0;
    exp_addr.delete(); exp_data.delete();
    foreach (prog[i]) begin
      last = with_last && (i == prog.size() - 1);
      if (model_bad(prog[i])) begin
        exp_err = 1;
      end else begin
        exp_addr.push_back(ptr);
        exp_data.push_back(model_word(prog[i]));
        ptr = (ptr + 1) % depth;
        exp_cnt++;
      end
      if (exp_cnt == depth && !last) exp_err = 1;
      if (last || exp_cnt == depth) break;
    end
  endtask

  task automatic drive(input tup_t t, input logic last);
    fmt = t.fmt; opcode = t.op; rs = t.rs; rt = t.rt; rd = t.rd; shamt = t.sh;
    funct = t.fn; imm = t.imm; address = t.adr; in_last = last; in_valid = 1'b1;
  endtask

  // Entered near a falling edge; returns at the falling edge after the accept.
  task automatic send(input tup_t t, input logic last, input bit use2);
    bit r, ok;
    ok = 0;
    drive(t, last);
    for (int i = 0; i < 50 && !ok; i++) begin
      #1 r = use2 ? w_rdy2 : w_rdy8;
      @(posedge clk);
      if (r) ok = 1;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", use2 ? w_rdy2 : w_rdy8);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({w_rdy8, w_we8, w_addr8, w_wd8, w_busy8, w_done8, w_cnt8, w_err8} !== '0) begin
        n_fail++;
        $display("FAIL reset8 cycle %0d: rdy=%b we=%b addr=%h wd=%h busy=%b done=%b cnt=%0d err=%b required all 0",
                 c, w_rdy8, w_we8, w_addr8, w_wd8, w_busy8, w_done8, w_cnt8, w_err8);
      end
      n_checks++;
      if ({w_rdy2, w_we2, w_addr2, w_wd2, w_busy2, w_done2, w_cnt2, w_err2} !== '0) begin
        n_fail++;
        $display("FAIL reset2 cycle %0d: outputs not all 0 (rdy=%b busy=%b cnt=%0d)", c, w_rdy2, w_busy2, w_cnt2);
      end
    end
  endtask

  task automatic test_directed();
    q8.delete();
    pulse_start();
    #1;
    n_checks++;
    if (w_busy8 !== 1'b1 || w_rdy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b in_ready=%b required 1 1", w_busy8, w_rdy8);
    end
    send(mk(2'd0, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0), 1'b0, 1'b0);
    n_checks++;
    if (w_we8 !== 1'b1 || w_addr8 !== 8'd0 || w_wd8 !== 32'h012A4020) begin
      n_fail++;
      $display("FAIL first_write: we=%b addr=%0d wdata=%h required 1 0 012a4020", w_we8, w_addr8, w_wd8);
    end
    send(mk(2'd1, 6'd8, 5'd9, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0), 1'b0, 1'b0);
    send(mk(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000), 1'b1, 1'b0);
    n_checks++;
    if (w_done8 !== 1'b1 || w_we8 !== 1'b1) begin
      n_fail++;
      $display("FAIL done_with_last_write: done=%b we=%b required 1 1", w_done8, w_we8);
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q8.size() != 3 || q8[0] !== {8'd0, 32'h012A4020} || q8[1] !== {8'd1, 32'h2128FFFF} ||
        q8[2] !== {8'd2, 32'h08100000}) begin
      n_fail++;
      $display("FAIL directed_writes: got %0d writes (first %h) required 3 writes 0:012a4020 1:2128ffff 2:08100000",
               q8.size(), q8.size() > 0 ? q8[0] : 40'h0);
    end
    n_checks++;
    if (w_done8 !== 1'b1 || w_cnt8 !== 9'd3 || w_err8 !== 1'b0 || w_busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_status: done=%b count=%0d err=%b busy=%b required 1 3 0 0",
               w_done8, w_cnt8, w_err8, w_busy8);
    end
  endtask

  task automatic test_random();
    for (int load = 0; load < 6; load++) begin
      int len;
      len = $urandom_range(1, 20);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(rand_tup(1'b1));
      model_run(256, 1'b1);
      q8.delete();
      pulse_start();
      foreach (prog[i]) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(prog[i], (i == prog.size() - 1), 1'b0);
      end
      n_checks++;
      if (w_done8 !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_done load %0d: done=%b required 1", load, w_done8);
      end
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (q8.size() != exp_addr.size()) begin
        n_fail++;
        $display("FAIL rand_nwrites load %0d: %0d writes required %0d", load, q8.size(), exp_addr.size());
      end else begin
        foreach (q8[i]) begin
          n_checks++;
          if (q8[i] !== {8'(exp_addr[i]), exp_data[i]}) begin
            n_fail++;
            $display("FAIL rand_write load %0d idx %0d: %h required %h", load, i, q8[i],
                     {8'(exp_addr[i]), exp_data[i]});
          end
        end
      end
      n_checks++;
      if (w_cnt8 !== 9'(exp_cnt) || w_err8 !== exp_err) begin
        n_fail++;
        $display("FAIL rand_status load %0d: count=%0d err=%b required %0d %b", load, w_cnt8, w_err8, exp_cnt, exp_err);
      end
    end
  endtask

  task automatic test_overflow();
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(rand_tup(1'b0));
    model_run(4, 1'b0);
    q2.delete();
    pulse_start();
    foreach (prog[i]) send(prog[i], 1'b0, 1'b1);
    #1;
    n_checks++;
    if (w_done2 !== 1'b1 || w_err2 !== 1'b1 || w_cnt2 !== 3'd4 || w_rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_status: done=%b err=%b count=%0d in_ready=%b required 1 1 4 0",
               w_done2, w_err2, w_cnt2, w_rdy2);
    end
    drive(rand_tup(1'b0), 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (w_rdy2 !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow_ready cycle %0d: in_ready=%b required 0", c, w_rdy2);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (q2.size() != 4) begin
      n_fail++;
      $display("FAIL overflow_nwrites: %0d writes required 4", q2.size());
    end else begin
      foreach (q2[i]) begin
        n_checks++;
        if (q2[i] !== {2'(exp_addr[i]), exp_data[i]}) begin
          n_fail++;
          $display("FAIL overflow_write %0d: %h required %h", i, q2[i], {2'(exp_addr[i]), exp_data[i]});
        end
      end
    end
  endtask

  task automatic test_reserved();
    for (int v = 0; v < 2; v++) begin
      prog.delete();
      prog.push_back(mk(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h21, 16'h0, 26'h0));
      if (v == 0) prog.push_back(mk(2'd3, 6'd8, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1234, 26'h1));
      else        prog.push_back(mk(2'd0, 6'd8, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20, 16'h0, 26'h0));
      prog.push_back(mk(2'd1, 6'd35, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0040, 26'h0));
      model_run(256, 1'b1);
      q8.delete();
      pulse_start();
      foreach (prog[i]) send(prog[i], (i == prog.size() - 1), 1'b0);
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (q8.size() != exp_addr.size() || (q8.size() > 0 && q8[0] !== {8'(exp_addr[0]), exp_data[0]}) ||
          (q8.size() > 1 && q8[q8.size()-1] !== {8'(exp_addr[q8.size()-1]), exp_data[q8.size()-1]})) begin
        n_fail++;
        $display("FAIL reserved_writes variant %0d: %0d writes required %0d", v, q8.size(), exp_addr.size());
      end
      n_checks++;
      if (w_err8 !== exp_err || w_cnt8 !== 9'(exp_cnt) || w_done8 !== 1'b1) begin
        n_fail++;
        $display("FAIL reserved_status variant %0d: err=%b count=%0d done=%b required %b %0d 1",
                 v, w_err8, w_cnt8, w_done8, exp_err, exp_cnt);
      end
    end
  endtask

  task automatic test_abort();
    tup_t t;
    pulse_start();
    send(rand_tup(1'b0), 1'b0, 1'b0);
    send(mk(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0), 1'b0, 1'b0);
    t = mk(2'd1, 6'd13, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'hBEEF, 26'h0);
    drive(t, 1'b0);
    start = 1'b1;
    #1;
    n_checks++;
    if (w_rdy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b during start required 0", w_rdy8);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (w_err8 !== 1'b0 || w_cnt8 !== 9'd0 || w_we8 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: err=%b count=%0d we=%b required 0 0 0", w_err8, w_cnt8, w_we8);
    end
    send(t, 1'b1, 1'b0);
    n_checks++;
    if (w_we8 !== 1'b1 || w_addr8 !== 8'd0 || w_wd8 !== model_word(t)) begin
      n_fail++;
      $display("FAIL abort_restart_write: we=%b addr=%0d wdata=%h required 1 0 %h",
               w_we8, w_addr8, w_wd8, model_word(t));
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    send(rand_tup(1'b0), 1'b0, 1'b0);
    send(rand_tup(1'b0), 1'b0, 1'b0);
    drive(rand_tup(1'b0), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({w_rdy8, w_we8, w_addr8, w_wd8, w_busy8, w_done8, w_cnt8, w_err8} !== '0 ||
        {w_rdy2, w_we2, w_addr2, w_wd2, w_busy2, w_done2, w_cnt2, w_err2} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b we=%b addr=%h busy=%b cnt=%0d required all 0",
               w_rdy8, w_we8, w_addr8, w_busy8, w_cnt8);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_busy8 !== 1'b0 || w_rdy8 !== 1'b0 || w_done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b in_ready=%b done=%b required 0 0 0", w_busy8, w_rdy8, w_done8);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overflow();
    test_reserved();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
